keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans a 4x3 matrix keypad by driving its columns and reading its rows.
- Debounces what it reads and presents one stable key as one-hot row/column levels. These feed KeypadToBcd directly (row1..row4, col1..col3).
- Also produces a held-key level and a single-cycle new-press strobe for downstream digit-entry logic.
- Keypad layout: row1 = 1 2 3, row2 = 4 5 6, row3 = 7 8 9, row4 = * 0 #; col1 is the left column.

Parameters:
SCAN_DIV, 1000, clock cycles per column slot (legal 4..65535)
DEBOUNCE_FRAMES, 20, consecutive identical scan frames required to accept a press or a release (legal 1..255)

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-high, single clock domain
key_row_n  input  4  raw keypad row lines, active-low, asynchronous; bit0 = row1
key_col_n  output  3  column drive, active-low, exactly one bit low; bit0 = col1
row1..row4  output  1 each  debounced one-hot row of the accepted key
col1..col3  output  1 each  debounced one-hot column of the accepted key
key_valid  output  1  high while a debounced key is held
key_press  output  1  one-cycle pulse on each new accepted press

Behaviour:
- Reset values:
  - key_col_n = 3'b110, column index = 0, divider = 0.
  - Synchronizer flops = 4'b1111.
  - FSM = IDLE, frame accumulator cleared.
  - row1..row4, col1..col3, key_valid, key_press all 0.
  - rst asserted at any point, including mid-press, restores all of the above on the next edge.
- Synchronizer: two flops on key_row_n. All logic uses only the synchronized value.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1.
  - On divider == SCAN_DIV-1: sample the synchronized rows for the current column into the frame accumulator, then advance the column index 0 -> 1 -> 2 -> 0.
  - key_col_n = ~(1 << index).
  - One frame = 3*SCAN_DIV cycles.
- Frame result:
  - Registered frame_done strobe fires one cycle after the column-2 sample.
  - Result is "none", or the highest-priority pressed key: lowest row first, then lowest column.
  - The accumulator then clears.
- Debounce FSM, advancing only on frame_done; cnt is 8-bit:
  - IDLE:
    - key -> CANDIDATE, cand = code, cnt = 1.
    - none -> stay.
  - CANDIDATE:
    - Same code: cnt+1. When cnt reaches DEBOUNCE_FRAMES -> PRESSED.
    - Different key: cand = new code, cnt = 1.
    - None -> IDLE.
    - If DEBOUNCE_FRAMES == 1, IDLE goes straight to PRESSED on the first key frame.
  - PRESSED:
    - Any key (same or different) -> stay; outputs unchanged, no rollover.
    - None -> RELEASE, cnt = 1; with DEBOUNCE_FRAMES == 1, go directly to IDLE instead.
  - RELEASE:
    - None: cnt+1. When cnt reaches DEBOUNCE_FRAMES -> IDLE.
    - Any key -> PRESSED; outputs held, no key_press.
- Outputs:
  - Registered and updated on the edge that enters PRESSED from CANDIDATE/IDLE: one row and one col high from cand, key_valid = 1, key_press = 1 for that cycle only.
  - On the edge entering IDLE from RELEASE, all outputs clear.
  - RELEASE keeps outputs and key_valid high.
  - Invariant: key_valid = 1 implies exactly one of row1..row4 and exactly one of col1..col3 is high; otherwise all are 0.
- Latency, clean press stable from frame start: accepted DEBOUNCE_FRAMES frames + 1 cycle after the first full frame containing it.

Test Plan:
- Bench parameters SCAN_DIV = 8, DEBOUNCE_FRAMES = 3 (frame = 24 cycles). Keypad model pulls key_row_n[r] low when the key at (r,c) is held and key_col_n[c] = 0.
1. Reset, then no keys -> key_col_n = 110 for 8 cycles, then 101, then 011, repeating; all outputs 0; key_press never asserted.
2. Hold '5' (row2, col2) from a frame boundary -> after 3 frames + 1 cycle: row2 = col2 = key_valid = 1; key_press high exactly 1 cycle; KeypadToBcd output = 4'd5. Release -> outputs clear after 3 empty frames.
3. '8' bounces (present/absent alternate frames for 4 frames), then stable -> accepted only after 3 consecutive frames; exactly one key_press; row3 = col2 = 1.
4. Hold '1' and '9' together -> row1 = col1 = 1 reported. Hold '5', then add '2' -> outputs stay row2/col2, no second key_press.
5. Hold '0' (row4, col2) and drop it for a single frame mid-hold -> key_valid stays 1, no new key_press. Full release -> clears 3 frames later.
6. Assert rst for 1 cycle while '7' is PRESSED -> all outputs 0 and key_col_n = 110 on the next edge; key still held -> re-accepted 3 frames later with one new key_press.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row synchronizer, frame-based
// debounce, one-hot row/col outputs with held level and new-press strobe.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row_n,
  output logic [2:0] key_col_n,
  output logic       row1,
  output logic       row2,
  output logic       row3,
  output logic       row4,
  output logic       col1,
  output logic       col2,
  output logic       col3,
  output logic       key_valid,
  output logic       key_press
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DF       = 8'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, CANDIDATE, PRESSED, RELEASE} state_t;

  logic [3:0]  sync1, sync2;
  logic [15:0] div;
  logic [1:0]  idx;
  logic        sample;
  logic        frame_done;
  logic [3:0]  acc0, acc1, acc2;

  logic        found;
  logic [1:0]  f_row, f_col;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  cand_row, cand_row_n, cand_col, cand_col_n;
  logic        load, clear;

  logic [3:0]  rows;
  logic [2:0]  cols;

  assign sample    = (div == DIV_LAST);
  assign key_col_n = ~(3'b001 << idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '1;
      sync2      <= '1;
      div        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      acc0       <= '0;
      acc1       <= '0;
      acc2       <= '0;
    end else begin
      sync1      <= key_row_n;
      sync2      <= sync1;
      frame_done <= sample && (idx == 2'd2);
      if (sample) begin
        div <= '0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        div <= div + 16'd1;
      end
      // A column sample can never coincide with frame_done (SCAN_DIV >= 4)
      if (frame_done) begin
        acc0 <= '0;
        acc1 <= '0;
        acc2 <= '0;
      end else if (sample) begin
        case (idx)
          2'd0:    acc0 <= ~sync2;
          2'd1:    acc1 <= ~sync2;
          default: acc2 <= ~sync2;
        endcase
      end
    end
  end

  // Lowest row wins, then lowest column within that row
  always_comb begin
    found = 1'b0;
    f_row = '0;
    f_col = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!found && acc0[r]) begin
        found = 1'b1; f_row = 2'(r); f_col = 2'd0;
      end
      if (!found && acc1[r]) begin
        found = 1'b1; f_row = 2'(r); f_col = 2'd1;
      end
      if (!found && acc2[r]) begin
        found = 1'b1; f_row = 2'(r); f_col = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cand_row <= '0;
      cand_col <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cand_row <= cand_row_n;
      cand_col <= cand_col_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    load       = 1'b0;
    clear      = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (found) begin
            cand_row_n = f_row;
            cand_col_n = f_col;
            cnt_n      = 8'd1;
            if (DF == 8'd1) begin
              state_n = PRESSED;
              load    = 1'b1;
            end else begin
              state_n = CANDIDATE;
            end
          end
        end
        CANDIDATE: begin
          if (!found) begin
            state_n = IDLE;
          end else if (f_row == cand_row && f_col == cand_col) begin
            cnt_n = cnt + 8'd1;
            if (cnt + 8'd1 == DF) begin
              state_n = PRESSED;
              load    = 1'b1;
            end
          end else begin
            cand_row_n = f_row;
            cand_col_n = f_col;
            cnt_n      = 8'd1;
          end
        end
        PRESSED: begin
          if (!found) begin
            cnt_n = 8'd1;
            if (DF == 8'd1) begin
              state_n = IDLE;
              clear   = 1'b1;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        default: begin
          if (found) begin
            state_n = PRESSED;
          end else begin
            cnt_n = cnt + 8'd1;
            if (cnt + 8'd1 == DF) begin
              state_n = IDLE;
              clear   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows      <= '0;
      cols      <= '0;
      key_valid <= 1'b0;
      key_press <= 1'b0;
    end else begin
      key_press <= load;
      if (load) begin
        rows      <= 4'b0001 << cand_row_n;
        cols      <= 3'b001 << cand_col_n;
        key_valid <= 1'b1;
      end else if (clear) begin
        rows      <= '0;
        cols      <= '0;
        key_valid <= 1'b0;
      end
    end
  end

  assign {row4, row3, row2, row1} = rows;
  assign {col3, col2, col1}       = cols;

endmodule
